// File: rtl/reg_scoreboard_issue.sv
// In-order issue slot that holds one decoded instruction, stalls it on RAW/WAW
// hazards against a busy bitmap, and presents its sources to the register file read port.
module reg_scoreboard_issue #(
  parameter int NUM_REG    = 8,
  parameter int NUM_W_PORT = 2,
  parameter int CNT_BIT    = 16,
  localparam int RID       = $clog2(NUM_REG)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_vld,
  output logic                        in_rdy,
  input  logic [RID-1:0]              in_src0,
  input  logic [RID-1:0]              in_src1,
  input  logic                        in_has_dst,
  input  logic [RID-1:0]              in_dst,
  output logic                        rd_addr_vld,
  input  logic                        rd_addr_rdy,
  output logic [RID-1:0]              rd_addr0,
  output logic [RID-1:0]              rd_addr1,
  input  logic [NUM_W_PORT-1:0]       wb_vld,
  input  logic [NUM_W_PORT*RID-1:0]   wb_addr,
  output logic [NUM_REG-1:0]          busy,
  output logic [CNT_BIT-1:0]          stall_cnt,
  output logic [1:0]                  dbg_state
);

  // Handshake rules (both ports): a transfer happens in a cycle where valid and
  // ready are both high; valid never depends on ready, and once raised, valid and
  // its payload hold steady until that transfer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_STALL = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e               state;

  logic                 hold_vld_q, hold_vld_d;
  logic [RID-1:0]       src0_q, src0_d;
  logic [RID-1:0]       src1_q, src1_d;
  logic                 has_dst_q, has_dst_d;
  logic [RID-1:0]       dst_q, dst_d;
  logic [NUM_REG-1:0]   busy_q, busy_d;
  logic [CNT_BIT-1:0]   stall_cnt_q, stall_cnt_d;

  logic [NUM_REG-1:0]   wb_clr;
  logic [NUM_REG-1:0]   eff_busy;
  logic [NUM_REG-1:0]   set_vec;
  logic                 hazard;
  logic                 fire;
  logic                 load;

  // Register 0 is never cleared here because it can never become busy.
  always_comb begin
    wb_clr = '0;
    for (int p = 0; p < NUM_W_PORT; p++) begin
      for (int r = 1; r < NUM_REG; r++) begin
        if (wb_vld[p] && (wb_addr[p*RID +: RID] == RID'(r))) begin
          wb_clr[r] = 1'b1;
        end
      end
    end
  end

  assign eff_busy = busy_q & ~wb_clr;
  assign hazard   = eff_busy[src0_q] | eff_busy[src1_q] | (has_dst_q & eff_busy[dst_q]);

  always_comb begin
    state = ST_EMPTY;
    if (hold_vld_q) begin
      state = hazard ? ST_STALL : ST_READY;
    end
  end

  assign rd_addr_vld = (state == ST_READY);
  assign fire        = rd_addr_vld && rd_addr_rdy;
  assign in_rdy      = !hold_vld_q || fire;
  assign load        = in_vld && in_rdy;

  always_comb begin
    hold_vld_d  = hold_vld_q;
    src0_d      = src0_q;
    src1_d      = src1_q;
    has_dst_d   = has_dst_q;
    dst_d       = dst_q;
    set_vec     = '0;
    stall_cnt_d = stall_cnt_q;

    if (load) begin
      hold_vld_d = 1'b1;
      src0_d     = in_src0;
      src1_d     = in_src1;
      has_dst_d  = in_has_dst;
      dst_d      = in_dst;
    end else if (fire) begin
      hold_vld_d = 1'b0;
    end

    if (fire && has_dst_q && (dst_q != '0)) begin
      set_vec[dst_q] = 1'b1;
    end

    if ((state == ST_STALL) && (stall_cnt_q != {CNT_BIT{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_BIT-1){1'b0}}, 1'b1};
    end
  end

  // A set from this cycle's issue outranks a writeback clear of the same register.
  assign busy_d = (busy_q & ~wb_clr) | set_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q  <= 1'b0;
      src0_q      <= '0;
      src1_q      <= '0;
      has_dst_q   <= 1'b0;
      dst_q       <= '0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      src0_q      <= src0_d;
      src1_q      <= src1_d;
      has_dst_q   <= has_dst_d;
      dst_q       <= dst_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rd_addr0  = src0_q;
  assign rd_addr1  = src1_q;
  assign busy      = busy_q;
  assign stall_cnt = stall_cnt_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_reg_scoreboard_issue.sv
// Directed plus random bench for reg_scoreboard_issue against a per-register
// reference model; two instances differ only in counter width.
module tb_reg_scoreboard_issue;

  localparam int NUM_REG    = 8;
  localparam int NUM_W_PORT = 2;
  localparam int RID        = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic                      in_vld;
  logic [RID-1:0]            in_src0, in_src1, in_dst;
  logic                      in_has_dst;
  logic                      rd_addr_rdy;
  logic [NUM_W_PORT-1:0]     wb_vld;
  logic [NUM_W_PORT*RID-1:0] wb_addr;

  logic                      in_rdy, rd_addr_vld;
  logic [RID-1:0]            rd_addr0, rd_addr1;
  logic [NUM_REG-1:0]        busy;
  logic [15:0]               stall_cnt;
  logic [1:0]                dbg_state;

  logic                      b_in_rdy, b_rd_addr_vld;
  logic [RID-1:0]            b_rd_addr0, b_rd_addr1;
  logic [NUM_REG-1:0]        b_busy;
  logic [3:0]                b_stall_cnt;
  logic [1:0]                b_dbg_state;

  reg_scoreboard_issue #(.NUM_REG(NUM_REG), .NUM_W_PORT(NUM_W_PORT), .CNT_BIT(16)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_src0(in_src0), .in_src1(in_src1), .in_has_dst(in_has_dst), .in_dst(in_dst),
    .rd_addr_vld(rd_addr_vld), .rd_addr_rdy(rd_addr_rdy),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .wb_vld(wb_vld), .wb_addr(wb_addr),
    .busy(busy), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  reg_scoreboard_issue #(.NUM_REG(NUM_REG), .NUM_W_PORT(NUM_W_PORT), .CNT_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(b_in_rdy),
    .in_src0(in_src0), .in_src1(in_src1), .in_has_dst(in_has_dst), .in_dst(in_dst),
    .rd_addr_vld(b_rd_addr_vld), .rd_addr_rdy(rd_addr_rdy),
    .rd_addr0(b_rd_addr0), .rd_addr1(b_rd_addr1),
    .wb_vld(wb_vld), .wb_addr(wb_addr),
    .busy(b_busy), .stall_cnt(b_stall_cnt), .dbg_state(b_dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit       m_hold;
  int       m_src0, m_src1, m_dst;
  bit       m_hasdst;
  bit       m_busy[NUM_REG];
  bit       m_clr[NUM_REG];
  int       m_cnt16, m_cnt4;
  bit       e_haz, e_vld, e_fire, e_inrdy, e_load;
  logic [2*RID-1:0] exp_q[$];

  task automatic model_reset();
    m_hold = 0; m_src0 = 0; m_src1 = 0; m_dst = 0; m_hasdst = 0;
    m_cnt16 = 0; m_cnt4 = 0;
    for (int r = 0; r < NUM_REG; r++) m_busy[r] = 0;
  endtask

  function automatic bit m_eff(input int r);
    return m_busy[r] && !m_clr[r];
  endfunction

  task automatic model_comb();
    for (int r = 0; r < NUM_REG; r++) begin
      m_clr[r] = 0;
      for (int p = 0; p < NUM_W_PORT; p++)
        if (wb_vld[p] && int'(wb_addr[p*RID +: RID]) == r && r != 0) m_clr[r] = 1;
    end
    e_haz   = m_hold && (m_eff(m_src0) || m_eff(m_src1) || (m_hasdst && m_eff(m_dst)));
    e_vld   = m_hold && !e_haz;
    e_fire  = e_vld && rd_addr_rdy;
    e_inrdy = !m_hold || e_fire;
    e_load  = in_vld && e_inrdy;
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    for (int r = 0; r < NUM_REG; r++)
      m_busy[r] = (m_busy[r] && !m_clr[r]) || (e_fire && m_hasdst && m_dst == r && r != 0);
    if (e_haz) begin
      m_cnt16 = (m_cnt16 + 1 > 65535) ? 65535 : m_cnt16 + 1;
      m_cnt4  = (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
    end
    if (e_load) begin
      m_hold = 1; m_src0 = int'(in_src0); m_src1 = int'(in_src1);
      m_hasdst = in_has_dst; m_dst = int'(in_dst);
    end else if (e_fire) begin
      m_hold = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_in(input bit v, input int s0, input int s1, input bit hd, input int d);
    in_vld = v; in_src0 = RID'(s0); in_src1 = RID'(s1); in_has_dst = hd; in_dst = RID'(d);
  endtask

  task automatic drive_wb(input logic [1:0] v, input int a0, input int a1);
    wb_vld = v; wb_addr = {RID'(a1), RID'(a0)};
  endtask

  // One cycle: check outputs against the model, then advance both across the edge.
  task automatic step();
    logic [NUM_REG-1:0] e_busy;
    logic [2*RID-1:0]   got;
    #2;
    model_comb();
    for (int r = 0; r < NUM_REG; r++) e_busy[r] = m_busy[r];
    chk("rd_addr_vld", 32'(rd_addr_vld), 32'(e_vld));
    chk("in_rdy", 32'(in_rdy), 32'(e_inrdy));
    chk("rd_addr0", 32'(rd_addr0), m_src0);
    chk("rd_addr1", 32'(rd_addr1), m_src1);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("stall_cnt16", 32'(stall_cnt), m_cnt16);
    chk("stall_cnt4", 32'(b_stall_cnt), m_cnt4);
    chk("b_rd_addr_vld", 32'(b_rd_addr_vld), 32'(e_vld));
    chk("b_busy", 32'(b_busy), 32'(e_busy));
    if (e_fire) exp_q.push_back({RID'(m_src1), RID'(m_src0)});
    if (rd_addr_vld && rd_addr_rdy) begin
      chk("fire_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        chk("fire_addr", 32'({rd_addr1, rd_addr0}), 32'(got));
      end
    end
    chk("fire_pending", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_in(0, 0, 0, 0, 0);
    drive_wb(2'b00, 0, 0);
    rd_addr_rdy = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1;
    drive_in(1, 0, 0, 0, 0);
    drive_wb(2'b00, 0, 0);
    rd_addr_rdy = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // reset held for two cycles with in_vld high
    drive_in(1, 2, 3, 1, 5);
    step();
    step();
    rst = 1'b0;
    drive_in(0, 0, 0, 0, 0);
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_stall_cnt", 32'(stall_cnt), 32'(0));
    #1;
    chk("reset_in_rdy", 32'(in_rdy), 32'(1));
    chk("reset_rd_addr_vld", 32'(rd_addr_vld), 32'(0));

    // back-to-back stream of independent writers
    do_reset();
    drive_in(1, 0, 0, 1, 1); step();
    drive_in(1, 0, 0, 1, 2); step();
    drive_in(1, 0, 0, 1, 3); step();
    drive_in(0, 0, 0, 0, 0); step();
    chk("stream_busy", 32'(busy), 32'h0E);

    // RAW stall released by a same-cycle writeback on port 1
    do_reset();
    drive_in(1, 0, 0, 1, 3); step();
    drive_in(1, 3, 0, 0, 0); step();
    drive_in(0, 0, 0, 0, 0);
    step(); step(); step();
    #1;
    chk("raw_stalled_vld", 32'(rd_addr_vld), 32'(0));
    chk("raw_stall_cnt", 32'(stall_cnt), 32'(3));
    drive_wb(2'b10, 0, 3);
    #1;
    chk("raw_bypass_vld", 32'(rd_addr_vld), 32'(1));
    step();
    drive_wb(2'b00, 0, 0);
    chk("raw_busy3_cleared", 32'(busy[3]), 32'(0));

    // WAW with the clear and the re-set landing on the same edge
    do_reset();
    drive_in(1, 0, 0, 1, 5); step();
    drive_in(1, 0, 0, 1, 5); step();
    drive_in(0, 0, 0, 0, 0); step();
    drive_wb(2'b01, 5, 0);
    #1;
    chk("waw_fire_vld", 32'(rd_addr_vld), 32'(1));
    step();
    drive_wb(2'b00, 0, 0);
    chk("waw_busy5_kept", 32'(busy[5]), 32'(1));

    // read-port backpressure without a hazard
    do_reset();
    drive_in(1, 1, 2, 1, 6); step();
    rd_addr_rdy = 1'b0;
    drive_in(1, 3, 4, 1, 7);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_vld", 32'(rd_addr_vld), 32'(1));
      chk("bp_in_rdy", 32'(in_rdy), 32'(0));
      chk("bp_addr0", 32'(rd_addr0), 32'(1));
      chk("bp_addr1", 32'(rd_addr1), 32'(2));
      step();
    end
    chk("bp_stall_cnt", 32'(stall_cnt), 32'(0));
    rd_addr_rdy = 1'b1;
    step();
    drive_in(0, 0, 0, 0, 0);
    step();

    // destination register 0 never becomes busy
    do_reset();
    drive_in(1, 0, 0, 1, 0); step();
    drive_in(0, 0, 0, 0, 0); step();
    chk("dst0_busy", 32'(busy), 32'(0));

    // long stall saturates the narrow counter
    do_reset();
    drive_in(1, 0, 0, 1, 4); step();
    drive_in(1, 0, 4, 0, 0); step();
    drive_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt4", 32'(b_stall_cnt), 32'hF);
    chk("sat_cnt16", 32'(stall_cnt), 32'd20);

    // random traffic with occasional mid-operation reset
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive_in($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 1), $urandom_range(0, 7));
      rd_addr_rdy = ($urandom_range(0, 3) != 0);
      drive_wb({($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
               $urandom_range(0, 7), $urandom_range(0, 7));
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
